// File: rtl/nes_mem_router.sv
// nes_mem_router: arbitrates CPU/PPU requests onto on-chip RAM regions or an external cart bus.
// Ports: clock/reset_n (async active-low); cpu_*/ppu_* request level + we/addr/wdata in, ack pulse + held rdata out;
//        ext_* backing-store request out, ext_ack/ext_rdata in; ext_err sticky timeout flag; busy = FSM not idle.
module nes_mem_router #(
   parameter int ADDR_W      = 22,
   parameter int DATA_W      = 8,
   parameter int LOCAL_AW    = 11,
   parameter int NUM_LOCAL   = 3,
   parameter int RR_MODE     = 0,
   parameter int EXT_TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ppu_req,
   input  logic              ppu_we,
   input  logic [ADDR_W-1:0] ppu_addr,
   input  logic [DATA_W-1:0] ppu_wdata,
   output logic              ppu_ack,
   output logic [DATA_W-1:0] ppu_rdata,
   output logic              ext_req,
   output logic              ext_we,
   output logic [ADDR_W-1:0] ext_addr,
   output logic [DATA_W-1:0] ext_wdata,
   input  logic              ext_ack,
   input  logic [DATA_W-1:0] ext_rdata,
   output logic              ext_err,
   output logic              busy
);
   localparam int CNT_W  = $clog2(EXT_TIMEOUT + 1);
   localparam int MEM_AW = LOCAL_AW + 2;
   localparam int MA_W   = $clog2(NUM_LOCAL << LOCAL_AW);
   typedef enum logic [1:0] {IDLE, LOCAL, EXT_WAIT, RESP} state_t;
   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ppu_rdata_q, ppu_rdata_d;
   logic [DATA_W-1:0] mem [NUM_LOCAL << LOCAL_AW];
   logic [MEM_AW-1:0] full_a;
   logic [MA_W-1:0]   mem_a;
   logic [DATA_W-1:0] mem_rd;
   logic              pick_ppu, is_local, rsp_set;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] rsp_data;
   // Region index sits just below the 2'b11 tag; regions are packed back to back
   assign full_a = {addr_q[ADDR_W-3 -: 2], addr_q[LOCAL_AW-1:0]};
   assign mem_a  = full_a[MA_W-1:0];
   assign mem_rd = mem[mem_a];
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      cpu_rdata_d = cpu_rdata_q;
      ppu_rdata_d = ppu_rdata_q;
      rsp_set     = 1'b0;
      rsp_data    = '0;
      // last_q = 1 means PPU was granted last, so round-robin hands a tie to the CPU
      pick_ppu = (cpu_req && ppu_req) ? ((RR_MODE != 0) ? ~last_q : 1'b1) : ppu_req;
      sel_addr = pick_ppu ? ppu_addr : cpu_addr;
      is_local = (sel_addr[ADDR_W-1 -: 2] == 2'b11) && ({1'b0, sel_addr[ADDR_W-3 -: 2]} < 3'(NUM_LOCAL));
      case (state_q)
         IDLE: if (cpu_req || ppu_req) begin
            gnt_d   = pick_ppu;
            last_d  = pick_ppu;
            we_d    = pick_ppu ? ppu_we : cpu_we;
            addr_d  = sel_addr;
            wdata_d = pick_ppu ? ppu_wdata : cpu_wdata;
            cnt_d   = '0;
            state_d = is_local ? LOCAL : EXT_WAIT;
         end
         LOCAL: begin
            rsp_set  = 1'b1;
            rsp_data = mem_rd;
            state_d  = RESP;
         end
         EXT_WAIT: if (ext_ack) begin
            rsp_set  = 1'b1;
            rsp_data = ext_rdata;
            state_d  = RESP;
         end else if (cnt_q == CNT_W'(EXT_TIMEOUT - 1)) begin
            // Last allowed wait cycle passed without ext_ack
            rsp_set  = 1'b1;
            rsp_data = '1;
            err_d    = 1'b1;
            state_d  = RESP;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // Read data lands as RESP is entered so it is valid alongside the ack
      if (rsp_set && !we_q) begin
         cpu_rdata_d = gnt_q ? cpu_rdata_q : rsp_data;
         ppu_rdata_d = gnt_q ? rsp_data : ppu_rdata_q;
      end
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         gnt_q       <= 1'b0;
         last_q      <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         cpu_rdata_q <= '0;
         ppu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         last_q      <= last_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         cpu_rdata_q <= cpu_rdata_d;
         ppu_rdata_q <= ppu_rdata_d;
      end
   end
   // RAM contents survive reset
   always_ff @(posedge clock) begin
      if (state_q == LOCAL && we_q) mem[mem_a] <= wdata_q;
   end
   assign cpu_ack   = (state_q == RESP) && !gnt_q;
   assign ppu_ack   = (state_q == RESP) && gnt_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ppu_rdata = ppu_rdata_q;
   assign ext_req   = state_q == EXT_WAIT;
   assign ext_we    = we_q;
   assign ext_addr  = addr_q;
   assign ext_wdata = wdata_q;
   assign ext_err   = err_q;
   assign busy      = state_q != IDLE;
endmodule

// File: doc/nes_mem_router.md
NES_MEM_ROUTER -- requirements
Module: nes_mem_router

Interface
REQ-001 Parameters SHALL be: ADDR_W, 22, request address width; DATA_W, 8, data width; LOCAL_AW, 11, local RAM word-address bits; NUM_LOCAL, 3 (1..4), number of on-chip RAM regions; RR_MODE, 0, 0 = fixed PPU priority, 1 = round-robin; EXT_TIMEOUT, 255 (>=2), max external wait cycles.
REQ-002 clock  in  1  single clock; all logic on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 cpu_req, ppu_req  in  1 each  request level, held until the matching ack.
REQ-005 cpu_we, ppu_we  in  1 each  write (1) / read (0) qualifier.
REQ-006 cpu_addr, ppu_addr  in  ADDR_W each  request address.
REQ-007 cpu_wdata, ppu_wdata  in  DATA_W each  write data.
REQ-008 cpu_ack, ppu_ack  out  1 each  one-cycle completion pulse.
REQ-009 cpu_rdata, ppu_rdata  out  DATA_W each  read data, valid with ack, held until the next ack on that port.
REQ-010 ext_req, ext_we, ext_addr[ADDR_W], ext_wdata[DATA_W]  out  backing-store (cart) request.
REQ-011 ext_ack  in  1, ext_rdata  in  DATA_W  backing-store completion.
REQ-012 ext_err  out  1  sticky timeout flag.
REQ-013 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-014 Decode: address is local iff addr[ADDR_W-1:ADDR_W-2]==2'b11 and idx=addr[ADDR_W-3:ADDR_W-4] < NUM_LOCAL; local word = addr[LOCAL_AW-1:0] in RAM idx; every other address is external.
REQ-015 Each local RAM SHALL be DATA_W x 2^LOCAL_AW, synchronous write, one-cycle registered read.
REQ-016 FSM states SHALL be IDLE, LOCAL, EXT_WAIT, RESP.
REQ-017 IDLE: on an edge with any req high, grant one port, latch its we/addr/wdata, and go to LOCAL (local) or EXT_WAIT (external).
REQ-018 Arbitration, RR_MODE=0: PPU wins whenever both requests are high.
REQ-019 Arbitration, RR_MODE=1: on a tie the port not granted last wins; the last-grant register resets to CPU, so PPU wins the first tie.
REQ-020 LOCAL: issue the RAM access (write on we=1); go to RESP next edge; ack pulses in RESP, so a local access is acked on the 2nd edge after grant.
REQ-021 EXT_WAIT: ext_req, ext_we, ext_addr, ext_wdata SHALL be driven from the latched request and held stable until ext_ack; on ext_ack, capture ext_rdata and go to RESP.
REQ-022 External timeout: a counter starts at 0 on entry to EXT_WAIT; if it reaches EXT_TIMEOUT without ext_ack, set ext_err, use rdata = all ones, and go to RESP.
REQ-023 ext_ack in the same cycle the timeout is reached SHALL count as success (no ext_err).
REQ-024 RESP: pulse the granted port's ack for exactly one cycle, update that port's rdata (reads only; writes leave rdata unchanged), then return to IDLE.
REQ-025 A request re-sampled high in IDLE on the cycle after its ack SHALL be treated as a new request; requesters SHALL deassert req in the ack cycle.
REQ-026 ext_req SHALL never be high outside EXT_WAIT; ext_ack received outside EXT_WAIT SHALL be ignored.
REQ-027 Write followed by read to the same local address SHALL return the written data.
REQ-028 ext_err SHALL clear only on reset.

Reset
REQ-029 While reset_n is low: FSM=IDLE; all acks, ext_req, ext_err and busy = 0; rdata, latched request and counter = 0; last-grant = CPU.
REQ-030 Reset mid-transaction SHALL abort it with no ack; local RAM contents are not cleared.

Verification
REQ-031 CPU write 0x5A to 0x380010, then read it back -> each ack arrives 2 edges after grant; read returns cpu_rdata=0x5A.
REQ-032 RR_MODE=1, cpu_req and ppu_req both held continuously -> grants alternate PPU, CPU, PPU, ...
REQ-033 RR_MODE=0, same stimulus -> PPU always wins each tie.
REQ-034 NUM_LOCAL=3, read of 0x3C0000 (idx 3) -> routed external: ext_req high with ext_addr=0x3C0000; ext_ack after 5 cycles with ext_rdata=0x33 -> ack with rdata=0x33.
REQ-035 EXT_TIMEOUT=4, external read with no ext_ack -> ext_err=1 and ack with rdata=0xFF after the timeout; ext_ack on the terminal cycle instead -> ext_err stays 0.
REQ-036 reset_n pulsed low during EXT_WAIT -> ext_req drops immediately, no ack is issued, and a later local read returns data written before the reset.
